// File: rtl/uart_pkg.sv
// Shared UART definitions: buffer sizing defaults and the TX FSM state encoding,
// kept here so the receive side can reuse them.
package uart_pkg;

    localparam int unsigned DefaultDepth = 16;
    localparam int unsigned DefaultAw    = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StSend = 2'd2,
        StGap  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO: storage, wrapping pointers and an occupancy count.
// full/empty come from the registered count, so they never see a same-cycle pop.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned AW    = DefaultAw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW-1:0] PtrOne   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CountOne = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CountMax = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CountMax);
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; stale bytes are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrOne;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte buffer in front of a UART transmitter: queues upstream writes and hands
// one byte at a time to the transmitter, with a forced idle gap between bytes.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned AW    = DefaultAw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    output logic          tx_enable_signal,
    output logic [7:0]    tx_data,
    input  logic          tx_done_signal,
    output logic [AW:0]   fill_level,
    output logic          busy,
    output logic          overflow
);

    tx_state_e  state_q;
    logic [7:0] fifo_head;
    logic       fifo_full, fifo_empty;
    logic       pop;

    assign pop = (state_q == StIdle) && !fifo_empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fill_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wr_ready = !fifo_full;
    assign busy     = (state_q != StIdle) || !fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= StIdle;
            tx_enable_signal <= 1'b0;
            tx_data          <= 8'h00;
            overflow         <= 1'b0;
        end else begin
            if (wr_en && fifo_full) overflow <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q <= StLoad;
                        tx_data <= fifo_head;
                    end
                end
                StLoad: begin
                    state_q          <= StSend;
                    tx_enable_signal <= 1'b1;
                end
                StSend: begin
                    if (tx_done_signal) begin
                        state_q          <= StGap;
                        tx_enable_signal <= 1'b0;
                    end
                end
                // One low cycle lets the transmitter restart its bit-rate counter.
                StGap: state_q <= StIdle;
                default: begin
                    state_q          <= StIdle;
                    tx_enable_signal <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: timing-rule reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_buffer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       tx_enable_signal;
    logic [7:0] tx_data;
    logic       tx_done_signal;
    logic [4:0] fill_level;
    logic       busy;
    logic       overflow;

    uart_tx_buffer #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .wr_en            (wr_en),
        .wr_data          (wr_data),
        .wr_ready         (wr_ready),
        .tx_enable_signal (tx_enable_signal),
        .tx_data          (tx_data),
        .tx_done_signal   (tx_done_signal),
        .fill_level       (fill_level),
        .busy             (busy),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the handoff timing rules
    // (pop -> enable one edge later, done -> at least two edges before the next pop).
    logic [7:0] m_q[$];
    bit         m_en   = 1'b0;
    bit         m_pend = 1'b0;
    int         m_gap  = 0;
    logic [7:0] m_data = 8'h00;
    bit         m_ovf  = 1'b0;

    task automatic model_reset();
        m_q.delete();
        m_en = 1'b0; m_pend = 1'b0; m_gap = 0; m_data = 8'h00; m_ovf = 1'b0;
    endtask

    task automatic model_edge();
        bit accept, popping;
        accept  = wr_en && (m_q.size() < DEPTH);
        popping = !m_en && !m_pend && (m_gap == 0) && (m_q.size() > 0);
        if (wr_en && !accept) m_ovf = 1'b1;
        if (m_en && tx_done_signal) begin
            m_en  = 1'b0;
            m_gap = 1;
        end else if (m_gap > 0) begin
            m_gap--;
        end
        if (m_pend) begin
            m_en   = 1'b1;
            m_pend = 1'b0;
        end
        if (popping) begin
            m_data = m_q.pop_front();
            m_pend = 1'b1;
        end
        if (accept) m_q.push_back(wr_data);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_edge();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                check("fill_level", 32'(fill_level), 32'(m_q.size()));
                check("wr_ready", 32'(wr_ready), 32'(m_q.size() < DEPTH));
                check("tx_enable", 32'(tx_enable_signal), 32'(m_en));
                check("tx_data", 32'(tx_data), 32'(m_data));
                check("overflow", 32'(overflow), 32'(m_ovf));
                check("busy", 32'(busy),
                      32'(m_en || m_pend || (m_gap > 0) || (m_q.size() > 0)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic drain();
        tx_done_signal = 1'b1;
        for (int i = 0; i < 300 && busy; i++) step();
        tx_done_signal = 1'b0;
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    int         idx;
    int         low_run;
    logic       prev_en;
    int         wr_pct;
    int         pcts[6] = '{20, 60, 95, 40, 10, 75};

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_done_signal = 1'b0;
        repeat (3) step();
        cmp_on = 1'b1;
        check("rst_tx_enable", 32'(tx_enable_signal), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        step();

        // Single byte latency
        write_byte(8'hA5);
        check("t1_fill_e", 32'(fill_level), 32'd1);
        check("t1_en_e", 32'(tx_enable_signal), 32'd0);
        step();
        check("t1_data_e1", 32'(tx_data), 32'hA5);
        check("t1_fill_e1", 32'(fill_level), 32'd0);
        check("t1_en_e1", 32'(tx_enable_signal), 32'd0);
        step();
        check("t1_en_e2", 32'(tx_enable_signal), 32'd1);
        repeat (3) step();
        check("t1_en_held", 32'(tx_enable_signal), 32'd1);
        check("t1_data_held", 32'(tx_data), 32'hA5);
        tx_done_signal = 1'b1; step(); tx_done_signal = 1'b0;
        check("t1_en_after_done", 32'(tx_enable_signal), 32'd0);
        check("t1_busy_gap", 32'(busy), 32'd1);
        tx_done_signal = 1'b1; step(); tx_done_signal = 1'b0;
        check("t1_spurious_gap", 32'(busy), 32'd0);
        tx_done_signal = 1'b1; step(); tx_done_signal = 1'b0;
        check("t1_spurious_idle", 32'(fill_level), 32'd0);

        // Burst of 16 bytes, then measure order and inter-byte gaps
        for (int k = 0; k < 16; k++) write_byte(8'(k + 1));
        check("t2_no_overflow", 32'(overflow), 32'd0);
        check("t2_first_en", 32'(tx_enable_signal), 32'd1);
        check("t2_first_data", 32'(tx_data), 32'h01);
        idx = 1; low_run = 0; prev_en = 1'b1;
        tx_done_signal = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx_enable_signal && !prev_en) begin
                check("t2_gap_len", 32'(low_run), 32'd3);
                check("t2_order", 32'(tx_data), 32'(idx + 1));
                idx++;
                low_run = 0;
            end
            if (!tx_enable_signal) low_run++;
            prev_en = tx_enable_signal;
        end
        tx_done_signal = 1'b0;
        check("t2_count", 32'(idx), 32'd16);

        // Overflow: one byte parks in the transmitter, 16 more fill the FIFO
        for (int k = 0; k < 17; k++) write_byte(8'(8'h40 + k));
        check("t3_fill_full", 32'(fill_level), 32'd16);
        check("t3_not_ready", 32'(wr_ready), 32'd0);
        check("t3_no_ovf_yet", 32'(overflow), 32'd0);
        write_byte(8'hFF);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_fill_kept", 32'(fill_level), 32'd16);

        // Write and pop on the same edge while full: write rejected
        tx_done_signal = 1'b1; step(); tx_done_signal = 1'b0;
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        check("t4_fill_d1", 32'(fill_level), 32'd16);
        step();
        wr_en = 1'b0;
        check("t4_fill_d2", 32'(fill_level), 32'd15);
        drain();
        check("t4_ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-byte with three bytes queued
        for (int k = 0; k < 4; k++) write_byte(8'(8'h11 + k));
        for (int i = 0; i < 10 && !tx_enable_signal; i++) step();
        check("t5_wait_en", 32'(tx_enable_signal), 32'd1);
        check("t5_queued", 32'(fill_level), 32'd3);
        #3 rst = 1'b0;
        #1;
        check("t5_en_async", 32'(tx_enable_signal), 32'd0);
        check("t5_fill_async", 32'(fill_level), 32'd0);
        check("t5_busy_async", 32'(busy), 32'd0);
        check("t5_ovf_async", 32'(overflow), 32'd0);
        step(); step();
        rst = 1'b1;
        step();
        write_byte(8'h3C);
        check("t5_fill_e", 32'(fill_level), 32'd1);
        step();
        check("t5_data_e1", 32'(tx_data), 32'h3C);
        check("t5_en_e1", 32'(tx_enable_signal), 32'd0);
        step();
        check("t5_en_e2", 32'(tx_enable_signal), 32'd1);
        drain();

        // Randomized traffic with varying write pressure and an async reset
        for (int b = 0; b < 6; b++) begin
            wr_pct = pcts[b];
            if (b == 3) begin
                #3 rst = 1'b0;
                step();
                rst = 1'b1;
            end
            for (int i = 0; i < 500; i++) begin
                wr_en          = ($urandom_range(99) < wr_pct);
                wr_data        = 8'($urandom);
                tx_done_signal = ($urandom_range(3) == 0);
                step();
            end
        end
        wr_en = 1'b0;
        drain();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
